// File: rtl/seq_detect_param_if.sv
// Serial input / match output bundle for seq_detect_param.
// master drives the stream and controls; slave is the detector.
interface seq_detect_param_if #(
   parameter int W     = 4,
   parameter int CNT_W = 8
);
   logic             x;
   logic             x_valid;
   logic             overlap;
   logic             pat_load;
   logic [W-1:0]     pat_in;
   logic             cnt_clr;
   logic             z;
   logic [CNT_W-1:0] match_cnt;

   modport master (
      output x, x_valid, overlap, pat_load, pat_in, cnt_clr,
      input  z, match_cnt
   );

   modport slave (
      input  x, x_valid, overlap, pat_load, pat_in, cnt_clr,
      output z, match_cnt
   );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with run-time reload.
// Define SEQ_DETECT_MATCH_CNT_EN to build the saturating match counter.
module seq_detect_param #(
   parameter int           W       = 4,
   parameter logic [W-1:0] PATTERN = 4'b1001,
   parameter int           CNT_W   = 8
) (
   input logic              clk,
   input logic              rst,
   seq_detect_param_if.slave bus
);
   localparam int FW = $clog2(W + 1);
   localparam logic [FW-1:0] FULL = FW'(W);

   logic [W-1:0]  pat_q, pat_d;
   logic [W-1:0]  hist_q, hist_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [FW-1:0] fill_inc;
   logic          z_q, z_d;
   logic          match;

   // State register: pattern, history, fill level and match pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q  <= PATTERN;
         hist_q <= '0;
         fill_q <= '0;
         z_q    <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         z_q    <= z_d;
      end
   end

   // Next state: reload wins over data; a match needs a full window
   always_comb begin
      pat_d    = pat_q;
      hist_d   = hist_q;
      fill_d   = fill_q;
      fill_inc = fill_q;
      match    = 1'b0;
      z_d      = 1'b0;
      if (bus.pat_load) begin
         pat_d  = bus.pat_in;
         hist_d = '0;
         fill_d = '0;
      end else if (bus.x_valid) begin
         hist_d   = {hist_q[W-2:0], bus.x};
         fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;
         match    = (hist_d == pat_q) && (fill_inc == FULL);
         fill_d   = (match && !bus.overlap) ? '0 : fill_inc;
         z_d      = match;
      end
   end

   // Output: registered match pulse
   assign bus.z = z_q;

`ifdef SEQ_DETECT_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter next value: clear yields 1 if a match lands with it
   always_comb begin
      cnt_d = cnt_q;
      if (bus.cnt_clr)
         cnt_d = match ? CNT_W'(1) : '0;
      else if (match && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign bus.match_cnt = cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = bus.cnt_clr;
   assign bus.match_cnt  = '0;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed plus random bench for seq_detect_param.
// Reference model keeps accepted bits in a queue.
module tb_seq_detect_param;
   localparam int           W     = 4;
   localparam int           CNT_W = 2;
   localparam logic [W-1:0] PAT   = 4'b1001;
   localparam int           CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_detect_param_if #(.W(W), .CNT_W(CNT_W)) bus ();

   seq_detect_param #(.W(W), .PATTERN(PAT), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [W-1:0] m_pat;
   bit           m_q[$];
   logic         m_z;
   int           m_cnt;
   logic         ovl;

   function automatic int exp_cnt();
`ifdef SEQ_DETECT_MATCH_CNT_EN
      return m_cnt;
`else
      return 0;
`endif
   endfunction

   function automatic bit window_hit();
      if (m_q.size() != W) return 1'b0;
      for (int i = 0; i < W; i++)
         if (m_q[i] != m_pat[W-1-i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic step(input logic xi, input logic vi, input logic ov,
                       input logic ld, input logic [W-1:0] pin,
                       input logic clr, input logic rs, input int dz);
      bit m;
      bus.x        = xi;
      bus.x_valid  = vi;
      bus.overlap  = ov;
      bus.pat_load = ld;
      bus.pat_in   = pin;
      bus.cnt_clr  = clr;
      rst          = rs;
      @(posedge clk);
      if (rs) begin
         m_pat = PAT;
         m_q.delete();
         m_z   = 1'b0;
         m_cnt = 0;
      end else begin
         m = 1'b0;
         if (ld) begin
            m_pat = pin;
            m_q.delete();
         end else if (vi) begin
            m_q.push_back(xi);
            if (m_q.size() > W) void'(m_q.pop_front());
            m = window_hit();
            if (m && !ov) m_q.delete();
         end
         m_z = m;
         if (clr)    m_cnt = m ? 1 : 0;
         else if (m) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end
      #1;
      n_assert++;
      assert (bus.z === m_z) else begin
         n_fail++;
         $error("FAIL z: observed %b expected %b", bus.z, m_z);
      end
      n_assert++;
      assert (bus.match_cnt === CNT_W'(exp_cnt())) else begin
         n_fail++;
         $error("FAIL cnt: observed %0d expected %0d",
                bus.match_cnt, exp_cnt());
      end
      if (dz >= 0) begin
         n_assert++;
         assert (bus.z === dz[0]) else begin
            n_fail++;
            $error("FAIL z_dir: observed %b expected %0d", bus.z, dz);
         end
      end
   endtask

   task automatic bv(input logic xi, input int dz);
      step(xi, 1'b1, ovl, 1'b0, '0, 1'b0, 1'b0, dz);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, ovl, 1'b0, '0, 1'b0, 1'b0, 0);
   endtask

   task automatic do_rst();
      step(1'b0, 1'b0, ovl, 1'b0, '0, 1'b0, 1'b1, 0);
   endtask

   task automatic chk_cnt(input string tag, input int spec_val);
      int e;
`ifdef SEQ_DETECT_MATCH_CNT_EN
      e = spec_val;
`else
      e = 0 * spec_val;
`endif
      n_assert++;
      assert (bus.match_cnt === CNT_W'(e)) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d",
                tag, bus.match_cnt, e);
      end
   endtask

   initial begin
      ovl = 1'b1;
      m_pat = PAT;
      m_z = 1'b0;
      m_cnt = 0;
      do_rst();
      chk_cnt("reset_cnt", 0);

      bv(1, 0); bv(0, 0); bv(0, 0); bv(1, 1);
      idle();
      chk_cnt("basic_cnt", 1);

      do_rst();
      ovl = 1'b1;
      bv(1, 0); bv(0, 0); bv(0, 0); bv(1, 1);
      bv(0, 0); bv(0, 0); bv(1, 1);
      chk_cnt("ovl1_cnt", 2);

      do_rst();
      ovl = 1'b0;
      bv(1, 0); bv(0, 0); bv(0, 0); bv(1, 1);
      bv(0, 0); bv(0, 0); bv(1, 0);
      chk_cnt("ovl0_cnt", 1);

      do_rst();
      ovl = 1'b1;
      bv(1, 0); idle(); bv(0, 0); idle(); idle(); bv(0, 0); bv(1, 1);
      idle();

      do_rst();
      bv(1, 0); bv(0, 0); bv(0, 0);
      step(1'b1, 1'b1, ovl, 1'b1, 4'b0110, 1'b0, 1'b0, 0);
      bv(0, 0); bv(1, 0); bv(1, 0); bv(0, 1);
      bv(1, 0); bv(0, 0); bv(0, 0); bv(1, 0);
      step(1'b0, 1'b0, ovl, 1'b1, PAT, 1'b0, 1'b0, 0);

      do_rst();
      bv(1, 0); bv(0, 0); bv(0, 0);
      do_rst();
      bv(1, 0);
      chk_cnt("rst_mid_cnt", 0);

      do_rst();
      ovl = 1'b1;
      bv(1, 0);
      for (int k = 0; k < 5; k++) begin
         bv(0, 0); bv(0, 0); bv(1, 1);
      end
      chk_cnt("sat_cnt", 3);
      bv(0, 0); bv(0, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1);
      chk_cnt("clr_match_cnt", 1);
      step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 0);
      chk_cnt("clr_cnt", 0);

      step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 0);
      bv(1, 0); bv(1, 0); bv(1, 0); bv(1, 1); bv(1, 1);
      step(1'b0, 1'b0, 1'b1, 1'b1, PAT, 1'b0, 1'b0, 0);

      for (int k = 0; k < 600; k++) begin
         step(1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 29) == 0),
              W'($urandom_range(0, (1 << W) - 1)),
              1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 99) == 0),
              -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector for single-bit input streams. It is the successor to the fixed 1001 Moore/Mealy detector. The pattern length and value are set by parameters, the pattern can be reloaded at run time, input is qualified by a valid strobe, and overlapping or non-overlapping match counting is selectable. It sits on the serial input path and flags each occurrence of the pattern to downstream control logic.

## Interface
- `W`, default 4: pattern length in bits; legal range 2..32.
- `PATTERN`, default 4'b1001: reset value of the pattern register; `PATTERN[W-1]` is the first bit received.
- `CNT_W`, default 8: width of the match counter.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `x`, in, 1: serial data bit.
- `x_valid`, in, 1: `x` is consumed on a cycle where this is 1.
- `overlap`, in, 1: 1 = overlapping matches allowed; 0 = non-overlapping.
- `pat_load`, in, 1: load `pat_in` into the pattern register.
- `pat_in`, in, W: new pattern value.
- `cnt_clr`, in, 1: clear the match counter.
- `z`, out, 1: one-cycle match pulse.
- `match_cnt`, out, CNT_W: saturating match count.

## Operation
- **State:**
  - `pat` (W bits)
  - `hist` (W-bit shift register)
  - `fill` (0..W, counts accepted bits since the last clear)
  - `z` register
  - `match_cnt`
- **Accepted bit** (`x_valid`=1, `pat_load`=0):
  - `hist` <= {`hist`[W-2:0], `x`}.
  - `fill` <= min(`fill`+1, W).
- **Match:** the post-shift `hist` equals `pat` AND the post-increment `fill` == W.
  - A match sets `z`=1 for the next cycle only.
- **Non-match behaviour:** if `x_valid`=0, `hist` and `fill` hold and `z`=0 next cycle.
- **Overlap mode:**
  - `overlap`=1: `fill` stays at W after a match, so the trailing bits can start the next match.
  - `overlap`=0: a match forces `fill` to 0, so W fresh bits are required for the next match.
  - `overlap` is sampled every cycle; a change applies from the next accepted bit.
- **Pattern load** (`pat_load`=1):
  - `pat` <= `pat_in`; `hist` <= 0; `fill` <= 0; `z` <= 0.
  - Any `x_valid` in the same cycle is ignored.
  - `pat_load` has priority over `x_valid`.
- **Leading bits:** the all-zero `hist` after a clear never matches, because `fill` < W.
- **Counter:**
  - Increments by 1 on each match; saturates at 2^CNT_W-1, with no wrap.
  - `cnt_clr` and a match in the same cycle: result is 1.
  - `cnt_clr` with no match: result is 0.
- **Reset values:**
  - `pat`=`PATTERN`, `hist`=0, `fill`=0, `z`=0, `match_cnt`=0.
  - Reset mid-stream discards all partial history.

## Timing
- Latency: the `z` pulse appears in the cycle after the rising edge at which the last pattern bit is accepted, i.e. `z` is registered.
- `z` is never high for two consecutive cycles unless two consecutive accepted bits each complete a match.
  - Possible only with `overlap`=1 and a periodic pattern, e.g. all ones.
- `match_cnt` updates on the same edge that sets `z`.
- `pat_load` takes effect at the next edge; the first bit counted toward the new pattern is accepted one cycle after `pat_load`.
- `rst` overrides `pat_load`, `cnt_clr` and `x_valid` in the same cycle.

## Configuration
- `SEQ_DETECT_MATCH_CNT_EN` defined:
  - Match counter is implemented as described.
  - `cnt_clr` is functional.
- Macro undefined:
  - No counter flops.
  - `match_cnt` is tied to 0; `cnt_clr` is ignored.
  - `z` behaviour is unchanged.

## Test plan
- **Basic match:** reset; `W`=4, `PATTERN`=1001; bits 1,0,0,1 with `x_valid`=1 on consecutive cycles -> `z`=1 exactly one cycle after bit 4; `match_cnt`=1.
- **Overlap modes:** stream 1,0,0,1,0,0,1.
  - `overlap`=1 -> `z` pulses after bit 4 and after bit 7; `match_cnt`=2.
  - `overlap`=0 -> `z` pulses after bit 4 only; `match_cnt`=1.
- **Valid gaps:** bits 1,0,0,1 with `x_valid`=0 idle cycles inserted (1, idle, 0, idle, idle, 0, 1) -> single `z` one cycle after the final 1; `z`=0 during idles.
- **Runtime reload:** after 1,0,0, assert `pat_load` with `pat_in`=0110 while `x_valid`=1 and `x`=1.
  - That bit is ignored; no `z`.
  - Then 0,1,1,0 -> `z` after the last 0.
  - Then 1,0,0,1 -> no `z`.
- **Reset mid-stream:** bits 1,0,0; `rst` for one cycle; bit 1 -> no `z`; `match_cnt`=0.
- **Counter boundaries** (macro defined, `CNT_W`=2, `overlap`=1):
  - Five matches -> `match_cnt` saturates at 3.
  - `cnt_clr` coincident with a match -> `match_cnt`=1.
  - Macro undefined -> `match_cnt` stays 0.
